// File: rtl/rf_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_arb
// Description : Round-robin arbiter sharing the single write port of the
//               32x32 register file between N_REQ writeback sources. One
//               valid/ready request is accepted per cycle and forwarded
//               through a registered output stage. A requester may lock the
//               port for a burst of at most MAX_LOCK consecutive grants.
// Optional    : RF_WR_ARB_X0_DROP_EN - accepted writes to address 0 are
//               handshaked normally but leave o_wr_en low (x0 stays zero).
// Ports       : clk, rst_n (async, active low)
//               i_req_valid/i_req_lock [N_REQ]    request valid / lock
//               i_req_addr [5*N_REQ], i_req_data [32*N_REQ]
//               o_req_ready [N_REQ]  one-hot combinational grant
//               o_wr_en/o_wr_addr/o_wr_data/o_grant_id  registered write port
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arb #(
    parameter int N_REQ    = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ-1:0]      i_req_lock,
    input  logic [5*N_REQ-1:0]    i_req_addr,
    input  logic [32*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic                  o_wr_en,
    output logic [4:0]            o_wr_addr,
    output logic [31:0]           o_wr_data,
    output logic [2:0]            o_grant_id
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [7:0]         lock_cnt, lock_cnt_nxt;

    logic               found_hi, found_lo;
    logic [IDX_W-1:0]   idx_hi, idx_lo;
    logic               owner_valid;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic               xfer;
    logic [4:0]         sel_addr;
    logic [31:0]        sel_data;
    logic               sel_lock;
    logic               wr_en_nxt;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] k);
        if (k == IDX_W'(N_REQ - 1)) begin
            return '0;
        end
        return k + IDX_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Grant selection. The rotating search is split into two halves: the
    // lowest valid index at or above the pointer wins, otherwise the lowest
    // valid index below it (the wrapped part of the search).
    // ------------------------------------------------------------------------
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                if (IDX_W'(k) >= ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_W'(k);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = IDX_W'(k);
                end
            end
        end

        owner_valid = |(i_req_valid & (N_REQ'(1) << owner));

        if (state == LOCKED) begin
            grant_found = owner_valid;
            grant_idx   = owner;
        end else if (found_hi) begin
            grant_found = 1'b1;
            grant_idx   = idx_hi;
        end else begin
            grant_found = found_lo;
            grant_idx   = idx_lo;
        end

        // No handshake may complete while reset is held.
        grant_found = grant_found & rst_n;
    end

    assign o_req_ready = grant_found ? (N_REQ'(1) << grant_idx) : '0;
    assign xfer        = grant_found;

    // Payload of the granted requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                sel_addr = i_req_addr[5*k +: 5];
                sel_data = i_req_data[32*k +: 32];
                sel_lock = i_req_lock[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lock FSM and pointer. lock_cnt holds the number of grants already given
    // in the current burst, so the grant that brings it to MAX_LOCK ends the
    // burst. With MAX_LOCK == 1 the first grant is already the last one, so
    // the lock is never entered.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        lock_cnt_nxt = lock_cnt;

        case (state)
            UNLOCKED: begin
                if (xfer) begin
                    ptr_nxt = wrap_inc(grant_idx);
                    if (sel_lock && (MAX_LOCK > 1)) begin
                        state_nxt    = LOCKED;
                        owner_nxt    = grant_idx;
                        lock_cnt_nxt = 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (!sel_lock || (lock_cnt == 8'(MAX_LOCK - 1))) begin
                        state_nxt    = UNLOCKED;
                        lock_cnt_nxt = '0;
                        ptr_nxt      = wrap_inc(owner);
                    end else begin
                        lock_cnt_nxt = lock_cnt + 8'd1;
                    end
                end else begin
                    // Owner dropped valid: release without a grant.
                    state_nxt    = UNLOCKED;
                    lock_cnt_nxt = '0;
                    ptr_nxt      = wrap_inc(owner);
                end
            end
            default: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            owner    <= '0;
            ptr      <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port. Address, data and id only load on a transfer so
    // they keep their last values across idle cycles.
    // ------------------------------------------------------------------------
`ifdef RF_WR_ARB_X0_DROP_EN
    assign wr_en_nxt = xfer && (sel_addr != 5'd0);
`else
    assign wr_en_nxt = xfer;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_grant_id <= '0;
        end else begin
            o_wr_en <= wr_en_nxt;
            if (xfer) begin
                o_wr_addr  <= sel_addr;
                o_wr_data  <= sel_data;
                o_grant_id <= 3'(grant_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wr_arb
// Description : Self-checking bench for rf_wr_arb (N_REQ=4, MAX_LOCK=8).
//               Directed vector table, hand-written lock/reset sequences and
//               randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arb;

    localparam int N  = 4;
    localparam int ML = 8;
`ifdef RF_WR_ARB_X0_DROP_EN
    localparam bit X0_DROP = 1'b1;
`else
    localparam bit X0_DROP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_lock = '0;
    logic [5*N-1:0]    req_addr = '0;
    logic [32*N-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic [2:0]        grant_id;

    int tests = 0;
    int fails = 0;

    rf_wr_arb #(.N_REQ(N), .MAX_LOCK(ML)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_lock  (req_lock),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_ptr, m_owner, m_cnt;
    bit          m_locked;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_gid;

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
        e_en = 0; e_addr = 0; e_data = 0; e_gid = 0;
    endtask

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
        if (m_locked)
            return (((v >> m_owner) & 1) != 0) ? N'(1 << m_owner) : '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (((v >> k) & 1) != 0) return N'(1 << k);
        end
        return '0;
    endfunction

    task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] lk,
                              input logic [5*N-1:0] a, input logic [32*N-1:0] d);
        logic [N-1:0] r;
        int k;
        bit klock;
        r = model_ready(v);
        k = -1;
        for (int i = 0; i < N; i++) if (((r >> i) & 1) != 0) k = i;
        if (k >= 0) begin
            klock  = ((lk >> k) & 1) != 0;
            e_addr = 5'(a >> (5 * k));
            e_data = 32'(d >> (32 * k));
            e_gid  = 3'(k);
            e_en   = X0_DROP ? (e_addr != 0) : 1'b1;
            m_ptr  = (k + 1) % N;
            if (m_locked) begin
                m_cnt++;
                if (!klock || m_cnt >= ML) m_locked = 0;
            end else if (klock) begin
                m_cnt = 1; m_owner = k; m_locked = (ML > 1);
            end
        end else begin
            e_en = 0;
            if (m_locked) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] lk,
                         input logic [5*N-1:0] a, input logic [32*N-1:0] d,
                         output logic [N-1:0] rdy);
        logic [N-1:0] er;
        req_valid = v; req_lock = lk; req_addr = a; req_data = d;
        #1;
        rdy = req_ready;
        er  = model_ready(v);
        check("ready_model", 32'(rdy), 32'(er));
        model_step(v, lk, a, d);
        @(posedge clk); #1;
        check("wr_en_model",   32'(wr_en),   32'(e_en));
        check("wr_addr_model", 32'(wr_addr), 32'(e_addr));
        check("wr_data_model", wr_data, e_data);
        check("grant_id_model", 32'(grant_id), 32'(e_gid));
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]    v;
        logic [N-1:0]    lk;
        logic [5*N-1:0]  a;
        logic [32*N-1:0] d;
        logic [N-1:0]    rdy;
        logic            en;
        logic [4:0]      wa;
        logic [31:0]     wd;
        logic [2:0]      gid;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] v, input logic [5*N-1:0] a,
                                input logic [32*N-1:0] d, input logic [N-1:0] rdy,
                                input logic en, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [2:0] gid);
        vec_t t;
        t.v = v; t.lk = '0; t.a = a; t.d = d; t.rdy = rdy;
        t.en = en; t.wa = wa; t.wd = wd; t.gid = gid;
        return t;
    endfunction

    localparam int NV = 10;
    vec_t tv[NV];

    initial begin
        logic [N-1:0]    r;
        logic [N-1:0]    exp_r;
        logic [5*N-1:0]  a_rr, a_one, a_zero;
        logic [32*N-1:0] d_rr, d_one, d_x0;
        logic            cv[N];
        logic [4:0]      ca[N];
        logic [31:0]     cd[N];
        logic [N-1:0]    rv, rl;
        logic [5*N-1:0]  ra;
        logic [32*N-1:0] rd;

        a_rr   = {5'd4, 5'd3, 5'd2, 5'd1};
        d_rr   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        a_one  = {5'd0, 5'd5, 5'd0, 5'd0};
        d_one  = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        a_zero = '0;
        d_x0   = {32'h0, 32'h0, 32'h0, 32'h1234};

        // Round robin from pointer 0, then a single write, then an x0 write.
        tv[0] = mk(4'hF, a_rr, d_rr, 4'b0001, 1'b1, 5'd1, 32'hD0, 3'd0);
        tv[1] = mk(4'hF, a_rr, d_rr, 4'b0010, 1'b1, 5'd2, 32'hD1, 3'd1);
        tv[2] = mk(4'hF, a_rr, d_rr, 4'b0100, 1'b1, 5'd3, 32'hD2, 3'd2);
        tv[3] = mk(4'hF, a_rr, d_rr, 4'b1000, 1'b1, 5'd4, 32'hD3, 3'd3);
        tv[4] = mk(4'hF, a_rr, d_rr, 4'b0001, 1'b1, 5'd1, 32'hD0, 3'd0);
        tv[5] = mk(4'hF, a_rr, d_rr, 4'b0010, 1'b1, 5'd2, 32'hD1, 3'd1);
        tv[6] = mk(4'b0100, a_one, d_one, 4'b0100, 1'b1, 5'd5, 32'hDEADBEEF, 3'd2);
        tv[7] = mk(4'b0000, a_one, d_one, 4'b0000, 1'b0, 5'd5, 32'hDEADBEEF, 3'd2);
        tv[8] = mk(4'b0001, a_zero, d_x0, 4'b0001, !X0_DROP, 5'd0, 32'h1234, 3'd0);
        tv[9] = mk(4'b0000, a_zero, d_x0, 4'b0000, 1'b0, 5'd0, 32'h1234, 3'd0);

        // ---------------- reset ----------------
        model_reset();
        rst_n = 1'b0; req_valid = '1; req_lock = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready",   32'(req_ready), 32'h0);
        check("rst_wr_en",   32'(wr_en),     32'h0);
        check("rst_wr_addr", 32'(wr_addr),   32'h0);
        check("rst_wr_data", wr_data,        32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            cycle(tv[i].v, tv[i].lk, tv[i].a, tv[i].d, r);
            check("tbl_ready",    32'(r),        32'(tv[i].rdy));
            check("tbl_wr_en",    32'(wr_en),    32'(tv[i].en));
            check("tbl_wr_addr",  32'(wr_addr),  32'(tv[i].wa));
            check("tbl_wr_data",  wr_data,       tv[i].wd);
            check("tbl_grant_id", 32'(grant_id), 32'(tv[i].gid));
        end

        // ---------------- lock burst: pointer is 1 ----------------
        for (int c = 0; c < 12; c++) begin
            cycle(4'hF, 4'b0010, a_rr, d_rr, r);
            if (c < 8)       exp_r = 4'b0010;
            else if (c == 8) exp_r = 4'b0100;
            else if (c == 9) exp_r = 4'b1000;
            else if (c == 10) exp_r = 4'b0001;
            else             exp_r = 4'b0010;
            check("lock_burst", 32'(r), 32'(exp_r));
        end
        // Owner drops valid: lock released without a grant, pointer -> 2.
        cycle(4'h0, 4'h0, a_rr, d_rr, r);
        check("lock_drop", 32'(r), 32'h0);

        // ---------------- lock release by lock=0 ----------------
        cycle(4'b1000, 4'b1000, a_rr, d_rr, r);
        check("lock_rel_0", 32'(r), 32'h8);
        cycle(4'hF, 4'b1000, a_rr, d_rr, r);
        check("lock_rel_1", 32'(r), 32'h8);
        cycle(4'hF, 4'b1000, a_rr, d_rr, r);
        check("lock_rel_2", 32'(r), 32'h8);
        cycle(4'hF, 4'b0000, a_rr, d_rr, r);
        check("lock_rel_3", 32'(r), 32'h8);
        cycle(4'hF, 4'b0000, a_rr, d_rr, r);
        check("lock_rel_next", 32'(r), 32'h1);

        // ---------------- reset mid-burst ----------------
        cycle(4'b0100, 4'b0100, a_rr, d_rr, r);
        check("burst_pre_rst0", 32'(r), 32'h4);
        cycle(4'hF, 4'b0100, a_rr, d_rr, r);
        check("burst_pre_rst1", 32'(r), 32'h4);
        req_valid = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready",   32'(req_ready), 32'h0);
        check("midrst_wr_en",   32'(wr_en),     32'h0);
        check("midrst_wr_addr", 32'(wr_addr),   32'h0);
        check("midrst_wr_data", wr_data,        32'h0);
        check("midrst_gid",     32'(grant_id),  32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'hF, 4'b0100, a_rr, d_rr, r);
        check("post_rst_grant", 32'(r), 32'h1);

        // ---------------- randomized traffic ----------------
        for (int k = 0; k < N; k++) begin
            cv[k] = 1'b0; ca[k] = '0; cd[k] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            rv = '0; rl = '0; ra = '0; rd = '0;
            for (int k = 0; k < N; k++) begin
                if (!cv[k]) begin
                    cv[k] = ($urandom_range(0, 3) != 0);
                    ca[k] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
                    cd[k] = $urandom;
                end
                if (cv[k]) rv = rv | N'(1 << k);
                if ($urandom_range(0, 2) == 0) rl = rl | N'(1 << k);
                ra = ra | ((5*N)'(ca[k]) << (5 * k));
                rd = rd | ((32*N)'(cd[k]) << (32 * k));
            end
            cycle(rv, rl, ra, rd, r);
            for (int k = 0; k < N; k++)
                if (((r >> k) & 1) != 0) cv[k] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wr_arb.md
Name: rf_wr_arb

Overview:
- Round-robin arbiter that shares the single write port of the 32x32 2R1W register file between N_REQ requesters.
- Each requester presents a valid/ready write request. One request is granted per cycle and driven onto the register-file write port through a registered output stage.
- Optional lock lets one requester hold the port for a burst. Lock length is bounded by a counter.
- Sits between the execute/load/CSR writeback sources and the register file.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_LOCK, 8, maximum consecutive grants to one locked requester (1..255).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  N_REQ  per-requester request valid
- i_req_lock  in  N_REQ  per-requester lock request, sampled only with valid
- i_req_addr  in  5*N_REQ  write address; requester k uses bits [5k+4:5k]
- i_req_data  in  32*N_REQ  write data; requester k uses bits [32k+31:32k]
- o_req_ready  out  N_REQ  one-hot grant, combinational, at most one bit set
- o_wr_en  out  1  register-file write enable, registered
- o_wr_addr  out  5  register-file write address, registered
- o_wr_data  out  32  register-file write data, registered
- o_grant_id  out  3  index of the requester whose write is on the o_wr_* outputs, registered

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_grant_id=0.
  - Priority pointer=0, lock state cleared, lock counter=0.
  - o_req_ready=0 while rst_n=0.
- Handshake:
  - A transfer occurs for requester k when i_req_valid[k] && o_req_ready[k].
  - A requester must hold valid, addr and data stable until accepted. Ready may depend on valid; valid must not depend on ready.
- Arbitration (combinational, unlocked):
  - Search starts at the pointer p, then p+1 … N_REQ-1, then wraps to 0 … p-1. The first valid requester gets ready.
  - If no request is valid, ready=0 for all requesters.
- Pointer update:
  - On an unlocked transfer by k, the pointer becomes (k+1) mod N_REQ.
  - The pointer does not change in idle cycles.
- Latency:
  - A transfer in cycle t gives o_wr_en=1 with the matching addr/data/grant_id in cycle t+1.
  - No transfer in cycle t gives o_wr_en=0 in cycle t+1. addr, data and grant_id hold their last values.
  - Throughput is one write per cycle with no bubbles.
- Lock state machine, states UNLOCKED and LOCKED(owner, count):
  - UNLOCKED -> LOCKED: on a transfer by k with i_req_lock[k]=1. Owner=k, count=1.
  - In LOCKED, only the owner can get ready, and only while its valid is high. Other requesters see ready=0.
  - On each further owner transfer, count increments.
  - LOCKED -> UNLOCKED happens on any of:
    - an owner transfer with lock=0 (that transfer is still granted);
    - an owner transfer with count==MAX_LOCK, regardless of lock;
    - owner valid=0 in any cycle, with no grant that cycle.
  - On leaving LOCKED, the pointer becomes (owner+1) mod N_REQ.
- Boundary cases:
  - With MAX_LOCK=1, lock has no effect beyond a normal grant.
  - If all requesters are valid every cycle, each gets exactly one grant per N_REQ cycles.
  - Address 0 is passed through unchanged unless the optional feature is compiled in.
  - Reset asserted mid-burst clears lock and output immediately. A partially accepted burst is not replayed.

Optional Feature:
- Macro: RF_WR_ARB_X0_DROP_EN.
- Defined:
  - A request with addr==0 is still handshaked (ready as normal, pointer and lock update as normal).
  - The next cycle's o_wr_en is 0; o_wr_addr, o_wr_data and o_grant_id still load the request values.
  - This makes x0 hard-wired zero at the write side.
- Undefined: addr 0 writes are forwarded with o_wr_en=1.

Test Plan:
- Reset check: hold rst_n=0 with all valid=1 -> o_req_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0. Release rst_n -> first grant goes to req0.
- Single write: req2 valid, addr=5, data=0xDEADBEEF for 1 cycle -> ready[2]=1 that cycle. Next cycle o_wr_en=1, o_wr_addr=5, o_wr_data=0xDEADBEEF, o_grant_id=2. Cycle after: o_wr_en=0.
- Round robin: N_REQ=4, all valid continuously, lock=0 -> grant order 0,1,2,3,0,1,… with one write per cycle and no gaps.
- Lock burst: req1 valid+lock for 12 cycles, others valid, MAX_LOCK=8 -> req1 granted 8 consecutive cycles, then req2, req3, req0, then req1 again.
- Lock release: req3 lock=1 for 3 transfers then lock=0 on the 4th -> 4 consecutive req3 grants, then pointer=0 and req0 is granted next.
- X0 drop: with RF_WR_ARB_X0_DROP_EN, req0 addr=0, data=0x1234 -> ready[0]=1, next cycle o_wr_en=0. Without the macro -> o_wr_en=1, o_wr_addr=0.
